mem_stage_pipe: RTL and testbench

Parametrised memory-access stage with an integrated MEM/WB output register. It validates each load/store address against the data-memory depth and the natural alignment of the access size, performs sized and sign- or zero-extended accesses into an internal little-endian data memory with configurable access latency, and presents results to write-back through a valid/ready handshake. It sits between the EX/MEM register and the register-file write port.

---
 rtl/mem_stage_pipe.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: memory-access pipeline stage with an integrated MEM/WB result register.
//
// Checks each load/store address against the data-memory depth and the natural alignment of
// the access size. Valid accesses go to an internal little-endian data memory after MEM_LAT
// cycles. Loads are sign- or zero-extended to XLEN. Results are handed to write-back through
// a valid/ready handshake.
//
// Parameters
//   XLEN     datapath / memory word width (32 or 64)
//   DEPTH    data memory depth in XLEN-bit words (power of two, >= 2)
//   MEM_LAT  memory access latency in cycles (>= 1)
//   REG_W    destination register index width
//
// Ports
//   clk, rst                       clock; synchronous active-low reset
//   in_valid / in_ready            upstream handshake
//   mem_read, mem_write            load / store request (both high = store)
//   mem_to_reg, reg_write          write-back controls, passed through
//   size, sign_ext                 access size (0 B, 1 H, 2 W, 3 D); load extension
//   address, write_data            byte address; store data (low 8<<size bits used)
//   alu_result_in, write_reg_in    passed through to the result register
//   out_valid / out_ready          write-back handshake
//   alu_result_out, read_data_out  registered results
//   write_reg_out, mem_to_reg_out, reg_write_out  registered controls
//   inv_mem_addr                   held op had an invalid address

module mem_stage_pipe #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic             reg_write,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [XLEN-1:0]  address,
  input  logic [XLEN-1:0]  write_data,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [REG_W-1:0] write_reg_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_result_out,
  output logic [XLEN-1:0]  read_data_out,
  output logic [REG_W-1:0] write_reg_out,
  output logic             mem_to_reg_out,
  output logic             reg_write_out,
  output logic             inv_mem_addr
);

  localparam int unsigned ByteOffW = $clog2(XLEN / 8);
  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned CntW     = $clog2(MEM_LAT + 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  // Op latched on accept while the access is in flight.
  logic             lat_rd_q, lat_wr_q, lat_m2r_q, lat_rw_q, lat_sext_q;
  logic [1:0]       lat_size_q;
  logic [XLEN-1:0]  lat_addr_q, lat_wdata_q, lat_alu_q;
  logic [REG_W-1:0] lat_wreg_q;

  // Result register.
  logic             res_valid_q;
  logic [XLEN-1:0]  res_alu_q, res_rdata_q;
  logic [REG_W-1:0] res_wreg_q;
  logic             res_m2r_q, res_rw_q, res_inv_q;

  logic [XLEN-1:0] mem_q [DEPTH];

  // Operation currently being worked on: the input in IDLE, the latched op in ACCESS.
  logic             op_rd, op_wr, op_m2r, op_rw, op_sext;
  logic [1:0]       op_size;
  logic [XLEN-1:0]  op_addr, op_wdata, op_alu;
  logic [REG_W-1:0] op_wreg;

  always_comb begin
    if (state_q == StAccess) begin
      op_rd    = lat_rd_q;
      op_wr    = lat_wr_q;
      op_m2r   = lat_m2r_q;
      op_rw    = lat_rw_q;
      op_sext  = lat_sext_q;
      op_size  = lat_size_q;
      op_addr  = lat_addr_q;
      op_wdata = lat_wdata_q;
      op_alu   = lat_alu_q;
      op_wreg  = lat_wreg_q;
    end else begin
      op_rd    = mem_read;
      op_wr    = mem_write;
      op_m2r   = mem_to_reg;
      op_rw    = reg_write;
      op_sext  = sign_ext;
      op_size  = size;
      op_addr  = address;
      op_wdata = write_data;
      op_alu   = alu_result_in;
      op_wreg  = write_reg_in;
    end
  end

  // Address validation.
  logic op_mem, addr_hi_nz, misalign, size_bad, op_inv;

  assign op_mem     = op_rd | op_wr;
  // Any set bit above the word index means the word index is >= DEPTH.
  assign addr_hi_nz = |op_addr[XLEN-1:ByteOffW+IdxW];
  assign size_bad   = (XLEN == 32) && (op_size == 2'd3);

  always_comb begin
    misalign = 1'b0;
    unique case (op_size)
      2'd0: misalign = 1'b0;
      2'd1: misalign = op_addr[0];
      2'd2: misalign = |op_addr[1:0];
      2'd3: misalign = |op_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign op_inv = op_mem & (addr_hi_nz | misalign | size_bad);

  // Handshake and sequencing.
  logic accept, start_access, mem_done, res_load;

  assign in_ready     = (state_q == StIdle) && (!res_valid_q || out_ready);
  assign accept       = in_valid && in_ready;
  assign start_access = accept && op_mem && !op_inv && (MEM_LAT > 1);
  assign mem_done     = (MEM_LAT == 1) ? (accept && op_mem && !op_inv)
                                       : ((state_q == StAccess) && (cnt_q == CntW'(1)));
  assign res_load     = (accept && (!op_mem || op_inv)) || mem_done;

  // Data memory access: lane extraction for loads and byte-lane merge for stores.
  logic [IdxW-1:0]     word_idx;
  logic [ByteOffW-1:0] byte_off;
  logic [ByteOffW+2:0] bit_sh;
  logic [XLEN-1:0]     rd_word, rd_shift, lane_mask, load_val, be_mask, wd_shift, merged;
  logic                sign_bit, mem_we;

  assign word_idx = op_addr[ByteOffW+IdxW-1:ByteOffW];
  assign byte_off = op_addr[ByteOffW-1:0];
  assign bit_sh   = {byte_off, 3'b000};
  assign rd_word  = mem_q[word_idx];
  assign rd_shift = rd_word >> bit_sh;

  always_comb begin
    lane_mask = '1;
    sign_bit  = rd_shift[XLEN-1];
    unique case (op_size)
      2'd0: begin
        lane_mask = XLEN'(8'hff);
        sign_bit  = rd_shift[7];
      end
      2'd1: begin
        lane_mask = XLEN'(16'hffff);
        sign_bit  = rd_shift[15];
      end
      2'd2: begin
        lane_mask = XLEN'(32'hffff_ffff);
        sign_bit  = rd_shift[31];
      end
      2'd3: begin
        lane_mask = '1;
        sign_bit  = rd_shift[XLEN-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    load_val = rd_shift & lane_mask;
    if (op_sext && sign_bit) begin
      load_val = load_val | ~lane_mask;
    end
  end

  assign be_mask  = lane_mask << bit_sh;
  assign wd_shift = op_wdata << bit_sh;
  assign merged   = (rd_word & ~be_mask) | (wd_shift & be_mask);
  assign mem_we   = mem_done && op_wr;

  // Memory is not reset, but a store completing under active reset must not land.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[word_idx] <= merged;
    end
  end

  // Next result-register contents.
  logic [XLEN-1:0] res_rdata_d;
  logic            res_rw_d;

  always_comb begin
    res_rdata_d = '0;
    if (op_mem && !op_inv && !op_wr) begin
      res_rdata_d = load_val;
    end
  end

  assign res_rw_d = op_rw && !op_inv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lat_rd_q    <= 1'b0;
      lat_wr_q    <= 1'b0;
      lat_m2r_q   <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_sext_q  <= 1'b0;
      lat_size_q  <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_alu_q   <= '0;
      lat_wreg_q  <= '0;
      res_valid_q <= 1'b0;
      res_alu_q   <= '0;
      res_rdata_q <= '0;
      res_wreg_q  <= '0;
      res_m2r_q   <= 1'b0;
      res_rw_q    <= 1'b0;
      res_inv_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_access) begin
            state_q     <= StAccess;
            cnt_q       <= CntW'(MEM_LAT - 1);
            lat_rd_q    <= mem_read;
            lat_wr_q    <= mem_write;
            lat_m2r_q   <= mem_to_reg;
            lat_rw_q    <= reg_write;
            lat_sext_q  <= sign_ext;
            lat_size_q  <= size;
            lat_addr_q  <= address;
            lat_wdata_q <= write_data;
            lat_alu_q   <= alu_result_in;
            lat_wreg_q  <= write_reg_in;
          end
        end
        StAccess: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A new result takes priority over consumption, so out_valid stays high.
      if (res_load) begin
        res_valid_q <= 1'b1;
        res_alu_q   <= op_alu;
        res_rdata_q <= res_rdata_d;
        res_wreg_q  <= op_wreg;
        res_m2r_q   <= op_m2r;
        res_rw_q    <= res_rw_d;
        res_inv_q   <= op_inv;
      end else if (out_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid      = res_valid_q;
  assign alu_result_out = res_alu_q;
  assign read_data_out  = res_rdata_q;
  assign write_reg_out  = res_wreg_q;
  assign mem_to_reg_out = res_m2r_q;
  assign reg_write_out  = res_rw_q;
  assign inv_mem_addr   = res_inv_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
module tb_mem_stage_pipe;

  localparam int XLEN    = 64;
  localparam int DEPTH   = 1024;
  localparam int MEM_LAT = 2;
  localparam int REG_W   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic             mem_read, mem_write, mem_to_reg, reg_write;
  logic [1:0]       size;
  logic             sign_ext;
  logic [XLEN-1:0]  address, write_data, alu_result_in;
  logic [REG_W-1:0] write_reg_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_result_out, read_data_out;
  logic [REG_W-1:0] write_reg_out;
  logic             mem_to_reg_out, reg_write_out, inv_mem_addr;

  mem_stage_pipe #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .MEM_LAT(MEM_LAT),
    .REG_W  (REG_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .size          (size),
    .sign_ext      (sign_ext),
    .address       (address),
    .write_data    (write_data),
    .alu_result_in (alu_result_in),
    .write_reg_in  (write_reg_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result_out(alu_result_out),
    .read_data_out (read_data_out),
    .write_reg_out (write_reg_out),
    .mem_to_reg_out(mem_to_reg_out),
    .reg_write_out (reg_write_out),
    .inv_mem_addr  (inv_mem_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    logic [63:0]      alu;
    logic [63:0]      rd;
    logic [REG_W-1:0] wreg;
    logic             m2r;
    logic             rw;
    logic             inv;
    int               lat;
    int               acc;
  } exp_t;

  exp_t q[$];

  // Reference memory as a flat little-endian byte array.
  logic [7:0] mbytes [DEPTH*8];

  function automatic exp_t model(input logic mr, input logic mw, input logic m2r,
                                 input logic rw, input logic [1:0] sz, input logic sx,
                                 input logic [63:0] addr, input logic [63:0] wd,
                                 input logic [63:0] alu, input logic [REG_W-1:0] wr);
    exp_t        e;
    int          nb;
    bit          is_mem, bad;
    logic [63:0] v;
    nb     = 1 << sz;
    is_mem = mr || mw;
    bad    = is_mem && (((addr / 8) >= 64'(DEPTH)) || ((addr % 64'(nb)) != 0));
    e.alu  = alu;
    e.wreg = wr;
    e.m2r  = m2r;
    e.inv  = bad;
    e.rw   = rw && !bad;
    e.rd   = '0;
    e.lat  = (is_mem && !bad) ? MEM_LAT : 1;
    e.acc  = 0;
    if (is_mem && !bad) begin
      if (mw) begin
        for (int i = 0; i < nb; i++) mbytes[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (64'(mbytes[int'(addr) + i]) << (8 * i));
        if (sx && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
        e.rd = v;
      end
    end
    return e;
  endfunction

  // out_ready driver: 0 random, 1 always high, 2 always low.
  int rdy_mode = 1;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = (rdy_mode == 1);
    end
  end

  // Monitor: compares the presented result against the queue head every visible cycle,
  // checks latency on first sight and pops on consumption.
  bit seen = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen = 0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'(0));
        end else begin
          e = q[0];
          if (!seen) begin
            seen = 1;
            chk("latency", 64'(cyc - e.acc), 64'(e.lat - 1));
          end
          chk("alu_result_out", alu_result_out, e.alu);
          chk("read_data_out", read_data_out, e.rd);
          chk("write_reg_out", 64'(write_reg_out), 64'(e.wreg));
          chk("mem_to_reg_out", 64'(mem_to_reg_out), 64'(e.m2r));
          chk("reg_write_out", 64'(reg_write_out), 64'(e.rw));
          chk("inv_mem_addr", 64'(inv_mem_addr), 64'(e.inv));
          if (!out_ready) chk("in_ready_while_held", 64'(in_ready), 64'(0));
          else begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [1:0] sz, input logic sx, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] alu,
                       input logic [REG_W-1:0] wr, input bit track);
    exp_t e;
    int   n;
    in_valid      = 1'b1;
    mem_read      = mr;
    mem_write     = mw;
    mem_to_reg    = m2r;
    reg_write     = rw;
    size          = sz;
    sign_ext      = sx;
    address       = addr;
    write_data    = wd;
    alu_result_in = alu;
    write_reg_in  = wr;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
        return;
      end
    end
    if (track) begin
      e     = model(mr, mw, m2r, rw, sz, sx, addr, wd, alu, wr);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic alu_op(input logic [63:0] alu, input logic [REG_W-1:0] wr);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 64'h0, 64'h0, alu, wr, 1'b1);
  endtask

  task automatic st(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wd,
                    input bit track);
    issue(1'b0, 1'b1, 1'b0, 1'b0, sz, 1'b0, addr, wd, 64'($urandom), 5'($urandom), track);
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [63:0] addr);
    issue(1'b1, 1'b0, 1'b1, 1'b1, sz, sx, addr, 64'h0, 64'($urandom), 5'($urandom), 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    logic [1:0]  sz;
    logic [63:0] a;
    int          k, r, nb;
    logic        mr, mw;
    sz = 2'($urandom_range(0, 3));
    nb = 1 << sz;
    k  = $urandom_range(0, 9);
    r  = $urandom_range(0, 19);
    if (r < 16)      a = 64'($urandom_range(0, 255)) & ~64'(nb - 1);
    else if (r < 18) a = 64'($urandom_range(0, 255));
    else if (r < 19) a = 64'($urandom) | 64'h2000;
    else             a = {$urandom, $urandom} | 64'h100_0000_0000;
    mr = (k >= 3 && k <= 5) || k == 9;
    mw = (k >= 6);
    issue(mr, mw, 1'($urandom), 1'($urandom), sz, 1'($urandom), a,
          {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'b1);
  endtask

  initial begin
    int c0;
    rst = 1'b0;
    in_valid = 1'b0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
    size = 0; sign_ext = 0; address = 0; write_data = 0; alu_result_in = 0; write_reg_in = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_alu_result_out", alu_result_out, 64'(0));
    chk("reset_read_data_out", read_data_out, 64'(0));
    chk("reset_write_reg_out", 64'(write_reg_out), 64'(0));
    chk("reset_inv_mem_addr", 64'(inv_mem_addr), 64'(0));
    chk("reset_reg_write_out", 64'(reg_write_out), 64'(0));
    @(posedge clk);
    #1;

    // Give every byte of the region used below a known value.
    for (int w = 0; w < 32; w++) st(2'd3, 64'(w * 8), {$urandom, $urandom}, 1'b1);

    // Full-width store/load round trip, then sub-word lanes and extension.
    st(2'd3, 64'h40, 64'h1122334455667788, 1'b1);
    ld(2'd3, 1'b0, 64'h40);
    st(2'd0, 64'h43, 64'h80, 1'b1);
    ld(2'd0, 1'b1, 64'h43);
    ld(2'd0, 1'b0, 64'h43);
    ld(2'd3, 1'b0, 64'h40);

    // Misaligned and out-of-range accesses; memory word 0 must be left alone.
    ld(2'd2, 1'b0, 64'h42);
    st(2'd3, 64'd8192, 64'hA5A5A5A5A5A5A5A5, 1'b1);
    ld(2'd3, 1'b0, 64'h0);
    drain();

    // Backpressure: hold a result, then consume it on the same edge a new one loads.
    rdy_mode = 2;
    alu_op(64'hCAFE_0001, 5'd7);
    repeat (3) @(posedge clk);
    fork
      alu_op(64'hCAFE_0002, 5'd9);
      begin
        @(posedge clk);
        rdy_mode = 1;
      end
    join
    chk("out_valid_kept_on_swap", 64'(out_valid), 64'(1));
    drain();

    // Reset while a store is in flight: it must not write.
    st(2'd3, 64'h80, 64'hDEADBEEF_DEADBEEF, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    ld(2'd3, 1'b0, 64'h80);
    drain();

    // Back-to-back ALU ops: one accept per cycle.
    c0 = cyc;
    for (int i = 0; i < 8; i++) alu_op(64'(i * 3 + 1), 5'(i + 3));
    chk("b2b_cycles", 64'(cyc - c0), 64'(8));
    drain();

    // Randomized traffic with random backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 400; i++) rand_op();
    rdy_mode = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
